mem: RTL and testbench

//  Synchronous single-port RAM, DEPTH words x WIDTH bits, for the layered memory testbench.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_intf.sv | 57 +++++
 rtl/mem.sv | 70 +++++++
 tb/tb_mem.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the single-port RAM.
//   DEF_DEPTH / DEF_WIDTH : default geometry used by mem and mem_intf
//   mem_op_e              : decoded request type for one clock cycle
package mem_pkg;

  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE,
    OP_ERR
  } mem_op_e;

endpackage

// File: rtl/mem_intf.sv
// Connection bundle between the RAM and its bench.
//   clk      : clock supplied by the instantiating level
//   rst_n    : asynchronous active-low reset
//   read     : read request
//   write    : write request
//   addr     : word address, AW bits
//   data_in  : write data
//   data_out : registered read data (driven by mem)
//   err      : registered one-cycle error pulse (driven by mem)
// Modport mem is the RAM side, modport tb is the bench side.
interface mem_intf #(
  parameter int unsigned DEPTH = mem_pkg::DEF_DEPTH,
  parameter int unsigned WIDTH = mem_pkg::DEF_WIDTH
) (
  input bit clk
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             rst_n;
  logic             read;
  logic             write;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             err;

  // Samples the RAM outputs on the active edge for bench-side use.
  clocking cb @(posedge clk);
    input data_out;
    input err;
  endclocking

  modport mem (
    input  clk,
    input  rst_n,
    input  read,
    input  write,
    input  addr,
    input  data_in,
    output data_out,
    output err
  );

  modport tb (
    clocking cb,
    input  clk,
    output rst_n,
    output read,
    output write,
    output addr,
    output data_in,
    input  data_out,
    input  err
  );

endinterface

// File: rtl/mem.sv
// Synchronous single-port RAM, DEPTH words x WIDTH bits.
// All signals are reached through inf (mem_intf, modport mem):
//   in  clk, rst_n (async, active-low), read, write, addr, data_in
//   out data_out (registered read data), err (registered one-cycle error pulse)
// One read or one write per cycle. Simultaneous read+write, or an access to an
// address >= DEPTH, raises err for that cycle and leaves all state untouched.
module mem
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  mem_intf.mem inf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_data_out;
  logic             r_err;

  logic    w_rd;
  logic    w_wr;
  logic    w_addr_ok;
  mem_op_e w_op;

  // Case-equality so that X/Z on a request line counts as "not requested".
  always_comb begin
    w_rd      = (inf.read === 1'b1);
    w_wr      = (inf.write === 1'b1);
    w_addr_ok = (32'(inf.addr) < DEPTH);
    w_op      = OP_IDLE;
    if (w_rd && w_wr) begin
      w_op = OP_ERR;
    end else if ((w_rd || w_wr) && !w_addr_ok) begin
      w_op = OP_ERR;
    end else if (w_rd) begin
      w_op = OP_READ;
    end else if (w_wr) begin
      w_op = OP_WRITE;
    end
  end

  always_ff @(posedge inf.clk or negedge inf.rst_n) begin
    if (!inf.rst_n) begin
      r_mem      <= '{default: '0};
      r_data_out <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (w_op)
        OP_READ: begin
          r_data_out <= r_mem[inf.addr];
          r_err      <= 1'b0;
        end
        OP_WRITE: begin
          r_mem[inf.addr] <= inf.data_in;
          r_err           <= 1'b0;
        end
        OP_ERR: begin
          r_err <= 1'b1;
        end
        default: begin
          r_err <= 1'b0;
        end
      endcase
    end
  end

  assign inf.data_out = r_data_out;
  assign inf.err      = r_err;

endmodule

// File: tb/tb_mem.sv
// Bench for mem: a 32-word and a 20-word instance, checked against a plain
// array model that applies the request rules directly.
module tb_mem;

  bit clk;
  always #5 clk = ~clk;

  mem_intf #(.DEPTH(32), .WIDTH(8)) i32 (.clk(clk));
  mem_intf #(.DEPTH(20), .WIDTH(8)) i20 (.clk(clk));

  mem #(.DEPTH(32), .WIDTH(8)) u_dut32 (.inf(i32));
  mem #(.DEPTH(20), .WIDTH(8)) u_dut20 (.inf(i20));

  int tests = 0;
  int fails = 0;

  // Model: index 0 is the 32-word instance, index 1 the 20-word instance.
  logic [7:0] model [2][32];
  logic [7:0] exp_dout [2];
  logic       exp_err [2];

  task automatic chk(input logic [7:0] got, input logic [7:0] want, input string tag);
    tests++;
    assert (got === want) else begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, got, want);
      $error("comparison %s failed", tag);
    end
  endtask

  task automatic model_reset(input int s);
    for (int i = 0; i < 32; i++) model[s][i] = 8'h00;
    exp_dout[s] = 8'h00;
    exp_err[s]  = 1'b0;
  endtask

  // Apply one request for one cycle, then compare outputs 1 time unit after the edge.
  task automatic op(input int s, input bit rd, input bit wr, input int unsigned a,
                    input logic [7:0] d, input string tag);
    int unsigned depth;
    logic [4:0]  ai;
    bit          bad;
    depth = (s == 1) ? 20 : 32;
    ai    = a[4:0];
    @(negedge clk);
    if (s == 1) begin
      i20.read = rd; i20.write = wr; i20.addr = ai; i20.data_in = d;
    end else begin
      i32.read = rd; i32.write = wr; i32.addr = ai; i32.data_in = d;
    end
    @(posedge clk);
    #1;
    bad = (rd && wr) || ((rd || wr) && (a >= depth));
    exp_err[s] = bad;
    if (!bad && wr) model[s][ai] = d;
    if (!bad && rd) exp_dout[s] = model[s][ai];
    if (s == 1) begin
      chk(i20.data_out, exp_dout[1], {tag, "_dout"});
      chk({7'b0, i20.err}, {7'b0, exp_err[1]}, {tag, "_err"});
    end else begin
      chk(i32.data_out, exp_dout[0], {tag, "_dout"});
      chk({7'b0, i32.err}, {7'b0, exp_err[0]}, {tag, "_err"});
    end
  endtask

  initial begin
    i32.rst_n = 1'b0; i32.read = 1'b0; i32.write = 1'b0; i32.addr = '0; i32.data_in = '0;
    i20.rst_n = 1'b0; i20.read = 1'b0; i20.write = 1'b0; i20.addr = '0; i20.data_in = '0;
    model_reset(0);
    model_reset(1);

    // Reset held for two cycles; outputs must already be clear.
    #1;
    chk(i32.data_out, 8'h00, "rst_dout");
    chk({7'b0, i32.err}, 8'h00, "rst_err");
    @(negedge clk);
    @(negedge clk);
    i32.rst_n = 1'b1;
    i20.rst_n = 1'b1;

    for (int a = 0; a < 32; a++) op(0, 1'b1, 1'b0, a, 8'h00, "rst_read");

    // Address sweep: each word holds its own address.
    for (int a = 0; a < 32; a++) op(0, 1'b0, 1'b1, a, 8'(a), "sweep_wr");
    for (int a = 0; a < 32; a++) op(0, 1'b1, 1'b0, a, 8'h00, "sweep_rd");

    // Random writes then random reads.
    for (int n = 0; n < 64; n++) op(0, 1'b0, 1'b1, $urandom_range(31), 8'($urandom), "rnd_wr");
    for (int n = 0; n < 64; n++) op(0, 1'b1, 1'b0, $urandom_range(31), 8'h00, "rnd_rd");

    // Write immediately followed by read of the same word, then boundary word.
    op(0, 1'b0, 1'b1, 10, 8'h3C, "b2b_wr");
    op(0, 1'b1, 1'b0, 10, 8'h00, "b2b_rd");
    op(0, 1'b0, 1'b1, 31, 8'hC3, "last_wr");
    op(0, 1'b1, 1'b0, 31, 8'h00, "last_rd");

    // Conflict: read+write together flags err for one cycle and changes nothing.
    op(0, 1'b0, 1'b1, 3, 8'hA5, "cfl_wr");
    op(0, 1'b1, 1'b1, 3, 8'h5A, "cfl_both");
    op(0, 1'b0, 1'b0, 3, 8'h00, "cfl_idle");
    op(0, 1'b1, 1'b0, 3, 8'h00, "cfl_rd");

    // Reset mid-run, asserted between clock edges while err is high.
    op(0, 1'b0, 1'b1, 31, 8'hFF, "mrst_wr");
    op(0, 1'b1, 1'b0, 31, 8'h00, "mrst_rd0");
    op(0, 1'b1, 1'b1, 31, 8'h00, "mrst_cfl");
    #2;
    i32.rst_n = 1'b0;
    model_reset(0);
    #1;
    chk(i32.data_out, 8'h00, "mrst_dout_now");
    chk({7'b0, i32.err}, 8'h00, "mrst_err_now");
    #1;
    i32.rst_n = 1'b1;
    op(0, 1'b1, 1'b0, 31, 8'h00, "mrst_rd31");

    // 20-word instance: out-of-range accesses flag err and leave contents intact.
    for (int a = 0; a < 20; a++) op(1, 1'b0, 1'b1, a, 8'($urandom), "d20_wr");
    op(1, 1'b1, 1'b0, 19, 8'h00, "d20_rd19");
    op(1, 1'b0, 1'b1, 25, 8'hEE, "d20_wr25");
    op(1, 1'b1, 1'b0, 20, 8'h00, "d20_rd20");
    op(1, 1'b0, 1'b0, 0, 8'h00, "d20_idle");
    for (int a = 0; a < 20; a++) op(1, 1'b1, 1'b0, a, 8'h00, "d20_rd");

    @(negedge clk);
    i32.read = 1'b0; i32.write = 1'b0;
    i20.read = 1'b0; i20.write = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
